qkv_generator_seq: RTL

Sequential, parametrised successor to the combinational Q/K/V projection block. It computes Q = Wq·x, K = Wk·x and V = Wv·x for one normalized input vector, using three MAC units, one per matrix, time-multiplexed over OUT_DIM×IN_DIM cycles. Weights live in internal register banks loaded through a write port. It sits between the layer-norm stage and the attention score unit in the fusion core, with valid/ready on both sides.

---
 rtl/qkv_generator_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/qkv_generator_seq.sv
// Q/K/V projection: three MACs time-multiplexed over OUT_DIM*IN_DIM products, with a registered product stage.
// Optional macro QKV_SHIFT_EN adds frac_shift (round-half-up right shift of each row sum before saturation).
module qkv_generator_seq #(
  parameter int DATA_W  = 16,
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 6,
  parameter int OUT_W   = 32,
  parameter int ACC_W   = 40,
  parameter int AW      = $clog2(OUT_DIM*IN_DIM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_DIM*DATA_W-1:0] in_vec,
  input  logic                     w_we,
  input  logic [1:0]               w_sel,
  input  logic [AW-1:0]            w_addr,
  input  logic [DATA_W-1:0]        w_data,
`ifdef QKV_SHIFT_EN
  input  logic [5:0]               frac_shift,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_DIM*OUT_W-1:0] q_out,
  output logic [OUT_DIM*OUT_W-1:0] k_out,
  output logic [OUT_DIM*OUT_W-1:0] v_out,
  output logic [2:0]               overflow,
  output logic                     busy
);
  localparam int N  = OUT_DIM*IN_DIM;
  localparam int KW = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
  localparam int JW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int PW = 2*DATA_W;
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [JW-1:0]            j_q, j_d, prow_q, prow_d;
  logic                     iss_q, iss_d, pv_q, pv_d, plast_q, plast_d;
  logic [5:0]               sh_q, sh_d;
  logic [2:0]               ovf_q, ovf_d;
  logic signed [DATA_W-1:0] x_q [IN_DIM];
  logic signed [DATA_W-1:0] x_d [IN_DIM];
  logic signed [PW-1:0]     prod_q [3];
  logic signed [PW-1:0]     prod_d [3];
  logic signed [ACC_W-1:0]  acc_q [3];
  logic signed [ACC_W-1:0]  acc_d [3];
  logic signed [OUT_W-1:0]  out_q [3][OUT_DIM];
  logic signed [OUT_W-1:0]  out_d [3][OUT_DIM];
  logic signed [DATA_W-1:0] w_mem [3][N];
  logic [AW-1:0]            rd_addr;

  // Weight banks carry no reset so they survive an aborted vector.
  always_ff @(posedge clk) begin
    if (w_we && state_q != COMPUTE && w_sel != 2'd3 && int'(w_addr) < N)
      w_mem[w_sel][w_addr] <= w_data;
  end

  assign rd_addr   = AW'(int'(j_q) * IN_DIM + int'(k_q));
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == COMPUTE);
  assign out_valid = (state_q == DONE);
  assign overflow  = ovf_q;

  always_comb begin
    logic signed [ACC_W-1:0] sum_a;
    logic signed [SW-1:0]    t;
    state_d = state_q; k_d = k_q; j_d = j_q; iss_d = iss_q;
    pv_d = 1'b0; plast_d = plast_q; prow_d = prow_q; sh_d = sh_q; ovf_d = ovf_q;
    x_d = x_q; prod_d = prod_q; acc_d = acc_q; out_d = out_q;
    sum_a = '0; t = '0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = COMPUTE; k_d = '0; j_d = '0; iss_d = 1'b0; ovf_d = '0;
        for (int b = 0; b < 3; b++) acc_d[b] = '0;
        for (int k = 0; k < IN_DIM; k++) x_d[k] = in_vec[DATA_W*k +: DATA_W];
`ifdef QKV_SHIFT_EN
        sh_d = frac_shift;
`else
        sh_d = '0;
`endif
      end
      COMPUTE: begin
        // Issue stage: one product per bank per cycle until the last row/column.
        if (!iss_q) begin
          pv_d = 1'b1; plast_d = (k_q == KW'(IN_DIM-1)); prow_d = j_q;
          for (int b = 0; b < 3; b++) prod_d[b] = PW'(w_mem[b][rd_addr]) * PW'(x_q[k_q]);
          if (k_q == KW'(IN_DIM-1)) begin
            k_d = '0;
            if (j_q == JW'(OUT_DIM-1)) iss_d = 1'b1;
            else j_d = j_q + 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        // Accumulate stage; the final product of a row is folded, shifted, clamped and written back.
        if (pv_q) begin
          for (int b = 0; b < 3; b++) begin
            sum_a = acc_q[b] + ACC_W'(prod_q[b]);
            if (plast_q) begin
              t = SW'(sum_a);
              if (sh_q != 6'd0) t = (t + (SW'(1) <<< (sh_q - 6'd1))) >>> sh_q;
              if (t > MAX_V) begin
                out_d[b][prow_q] = {1'b0, {(OUT_W-1){1'b1}}}; ovf_d[b] = 1'b1;
              end else if (t < MIN_V) begin
                out_d[b][prow_q] = {1'b1, {(OUT_W-1){1'b0}}}; ovf_d[b] = 1'b1;
              end else begin
                out_d[b][prow_q] = t[OUT_W-1:0];
              end
              acc_d[b] = '0;
            end else begin
              acc_d[b] = sum_a;
            end
          end
          if (plast_q && prow_q == JW'(OUT_DIM-1)) state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; k_q <= '0; j_q <= '0; iss_q <= 1'b0;
      pv_q <= 1'b0; plast_q <= 1'b0; prow_q <= '0; sh_q <= '0; ovf_q <= '0;
      for (int k = 0; k < IN_DIM; k++) x_q[k] <= '0;
      for (int b = 0; b < 3; b++) begin
        prod_q[b] <= '0; acc_q[b] <= '0;
        for (int j = 0; j < OUT_DIM; j++) out_q[b][j] <= '0;
      end
    end else begin
      state_q <= state_d; k_q <= k_d; j_q <= j_d; iss_q <= iss_d;
      pv_q <= pv_d; plast_q <= plast_d; prow_q <= prow_d; sh_q <= sh_d; ovf_q <= ovf_d;
      x_q <= x_d; prod_q <= prod_d; acc_q <= acc_d; out_q <= out_d;
    end
  end

  always_comb begin
    q_out = '0; k_out = '0; v_out = '0;
    for (int j = 0; j < OUT_DIM; j++) begin
      q_out[OUT_W*j +: OUT_W] = out_q[0][j];
      k_out[OUT_W*j +: OUT_W] = out_q[1][j];
      v_out[OUT_W*j +: OUT_W] = out_q[2][j];
    end
  end
endmodule
